// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: round-robin selection among 16 request channels,
// one grant at a time, with abort on channel disable and optional per-grant
// timeout. The binary grant index drives an external 4-to-16 decoder whose
// enable is grant_en_o.
module dma_channel_arbiter #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] req_i,
   input  logic [15:0] ch_en_i,
   input  logic        done_i,
   output logic        grant_en_o,
   output logic [3:0]  grant_idx_o,
   output logic        start_o,
   output logic        abort_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_BUSY = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  rr_ptr_r;
   logic [15:0] cnt_r;
   logic        grant_en_r;
   logic [3:0]  grant_idx_r;
   logic        start_r;
   logic        abort_r;
   logic        timeout_r;

   logic [15:0] eligible_s;
   logic [3:0]  winner_s;
   logic        chan_on_s;
   logic        timeout_hit_s;

   // First set bit of elig at or above ptr, wrapping 15 -> 0.
   function automatic logic [3:0] rr_pick(input logic [15:0] elig, input logic [3:0] ptr);
      logic [3:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         idx = ptr + 4'(i);
         if (!found && elig[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // Combinational arbitration inputs: eligibility, winner and exit conditions.
   always_comb begin
      eligible_s    = req_i & ch_en_i;
      winner_s      = rr_pick(eligible_s, rr_ptr_r);
      chan_on_s     = ch_en_i[grant_idx_r];
      timeout_hit_s = (TIMEOUT_CYC != 16'd0) && (cnt_r == (TIMEOUT_CYC - 16'd1));
   end

   // Arbiter state machine with all outputs registered; pulses default low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         rr_ptr_r    <= 4'd0;
         cnt_r       <= 16'd0;
         grant_en_r  <= 1'b0;
         grant_idx_r <= 4'd0;
         start_r     <= 1'b0;
         abort_r     <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         start_r   <= 1'b0;
         abort_r   <= 1'b0;
         timeout_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               grant_en_r <= 1'b0;
               if (eligible_s != 16'd0) begin
                  state_r <= ST_ARB;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ARB: begin
               if (eligible_s != 16'd0) begin
                  grant_idx_r <= winner_s;
                  grant_en_r  <= 1'b1;
                  start_r     <= 1'b1;
                  cnt_r       <= 16'd0;
                  state_r     <= ST_BUSY;
               end else begin
                  grant_en_r  <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // Exit priority: completion beats disable beats timeout.
               if (done_i) begin
                  grant_en_r <= 1'b0;
                  rr_ptr_r   <= grant_idx_r + 4'd1;
                  state_r    <= ST_IDLE;
               end else if (!chan_on_s) begin
                  grant_en_r <= 1'b0;
                  abort_r    <= 1'b1;
                  rr_ptr_r   <= grant_idx_r + 4'd1;
                  state_r    <= ST_IDLE;
               end else if (timeout_hit_s) begin
                  grant_en_r <= 1'b0;
                  timeout_r  <= 1'b1;
                  rr_ptr_r   <= grant_idx_r + 4'd1;
                  state_r    <= ST_IDLE;
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  state_r    <= ST_BUSY;
               end
            end
            default: begin
               grant_en_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant_en_o  = grant_en_r;
   assign grant_idx_o = grant_idx_r;
   assign start_o     = start_r;
   assign abort_o     = abort_r;
   assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter built with TIMEOUT_CYC = 4.
module tb_dma_channel_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] ch_en;
   logic        done;
   logic        grant_en;
   logic [3:0]  grant_idx;
   logic        start;
   logic        abort_p;
   logic        timeout_p;

   int tests = 0;
   int fails = 0;
   int hi_cnt;

   dma_channel_arbiter #(.TIMEOUT_CYC(16'd4)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .ch_en_i     (ch_en),
      .done_i      (done),
      .grant_en_o  (grant_en),
      .grant_idx_o (grant_idx),
      .start_o     (start),
      .abort_o     (abort_p),
      .timeout_o   (timeout_p)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {15'd0, start}, 16'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 16'hFFFF;
      ch_en = 16'hFFFF;
      done  = 1'b0;

      // Reset holds everything low even with all channels requesting
      tick(); tick();
      chk("rst_outputs", {9'd0, grant_en, grant_idx, start, abort_p, timeout_p}, 16'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_edge1_no_grant", {15'd0, grant_en}, 16'd0);
      tick();
      chk("rst_edge2_grant_en", {15'd0, grant_en}, 16'd1);
      chk("rst_edge2_start", {15'd0, start}, 16'd1);
      chk("rst_edge2_idx", {12'd0, grant_idx}, 16'd0);
      tick();
      chk("start_one_cycle", {15'd0, start}, 16'd0);

      // Fresh reset so round-robin starts from pointer 0
      rst_n = 1'b0;
      req   = 16'h8001;
      #2;
      chk("async_rst_drop", {15'd0, grant_en}, 16'd0);
      tick();
      rst_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         wait_start("rr_start");
         chk("rr_idx", {12'd0, grant_idx}, (g % 2 == 0) ? 16'd0 : 16'd15);
         tick(); tick();
         done = 1'b1;
         if (g == 3) req = 16'h0000;
         tick();
         done = 1'b0;
         chk("rr_done_drop", {15'd0, grant_en}, 16'd0);
         chk("rr_no_pulse", {14'd0, abort_p, timeout_p}, 16'd0);
      end

      // done outside BUSY has no effect; index retained while idle
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      chk("idle_done_ignored", {13'd0, grant_en, abort_p, timeout_p}, 16'd0);
      chk("idle_idx_retained", {12'd0, grant_idx}, 16'd15);

      // Abort: grant channel 5, disable it, next search starts at 6
      req   = 16'h0061;
      ch_en = 16'hFFFE;
      wait_start("abort_start");
      chk("abort_idx5", {12'd0, grant_idx}, 16'd5);
      ch_en = 16'hFFDF;
      tick();
      chk("abort_pulse", {15'd0, abort_p}, 16'd1);
      chk("abort_drop", {14'd0, grant_en, timeout_p}, 16'd0);
      tick();
      chk("abort_one_cycle", {15'd0, abort_p}, 16'd0);
      wait_start("abort_next_start");
      chk("abort_next_idx6", {12'd0, grant_idx}, 16'd6);
      req  = 16'h0000;
      done = 1'b1;
      tick();
      done = 1'b0;
      ch_en = 16'hFFFF;

      // Timeout: grant held exactly 4 cycles, then timeout pulse
      req = 16'h0080;
      wait_start("to_start");
      chk("to_idx7", {12'd0, grant_idx}, 16'd7);
      req = 16'h0000;
      hi_cnt = 0;
      while (grant_en === 1'b1 && hi_cnt < 20) begin
         hi_cnt++;
         tick();
      end
      chk("to_high_cycles", 16'(hi_cnt), 16'd4);
      chk("to_pulse", {15'd0, timeout_p}, 16'd1);
      chk("to_no_abort", {15'd0, abort_p}, 16'd0);
      tick();
      chk("to_one_cycle", {15'd0, timeout_p}, 16'd0);

      // Priority: done and disable together -> plain completion
      req = 16'h0100;
      wait_start("pri_a_start");
      chk("pri_a_idx8", {12'd0, grant_idx}, 16'd8);
      req   = 16'h0000;
      ch_en = 16'hFEFF;
      done  = 1'b1;
      tick();
      done  = 1'b0;
      ch_en = 16'hFFFF;
      chk("pri_a_no_abort", {14'd0, grant_en, abort_p}, 16'd0);

      // Priority: done on the 4th BUSY cycle beats timeout
      req = 16'h0200;
      wait_start("pri_b_start");
      chk("pri_b_idx9", {12'd0, grant_idx}, 16'd9);
      req = 16'h0000;
      tick(); tick(); tick();
      chk("pri_b_still_granted", {15'd0, grant_en}, 16'd1);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("pri_b_no_timeout", {14'd0, grant_en, timeout_p}, 16'd0);

      // Async reset mid-BUSY between edges
      req = 16'h0400;
      wait_start("ar_start");
      chk("ar_idx10", {12'd0, grant_idx}, 16'd10);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_immediate", {9'd0, grant_en, grant_idx, start, abort_p, timeout_p}, 16'd0);
      tick();
      chk("ar_no_pulse", {13'd0, grant_en, abort_p, timeout_p}, 16'd0);
      rst_n = 1'b1;
      req   = 16'h0000;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
